// File: rtl/adc_scan_avg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_avg
//  Description : Channel controller and result averager for the 12-bit serial
//                ADC interface. Scans channels 0..NUM_CH-1 round-robin, drops
//                DISCARD settling conversions after each channel change, then
//                averages 2^AVG_LOG2 conversions and presents the result with
//                a one-cycle strobe.
//
//  Ports       : clk        - system clock (shared with the ADC interface)
//                reset      - synchronous, active-high reset
//                enable     - scan enable; low returns the block to idle
//                conv_done  - one-cycle pulse per finished conversion frame
//                result     - 12-bit conversion result, valid with conv_done
//                chan       - channel select driven to the ADC interface
//                avg_data   - averaged result, held until the next update
//                avg_chan   - channel that avg_data belongs to
//                avg_valid  - one-cycle strobe: avg_data/avg_chan updated
//                scan_done  - one-cycle strobe with avg_valid of last channel
//
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_avg #(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 2,
    parameter int DISCARD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        conv_done,
    input  logic [11:0] result,
    output logic [2:0]  chan,
    output logic [11:0] avg_data,
    output logic [2:0]  avg_chan,
    output logic        avg_valid,
    output logic        scan_done
);

    // Accumulator holds up to 2^AVG_LOG2 full-scale samples without overflow.
    localparam int c_ACC_W  = 12 + AVG_LOG2;
    localparam int c_SCNT_W = AVG_LOG2 + 1;

    localparam logic [c_SCNT_W-1:0] c_LAST_SAMP = c_SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [1:0]          c_LAST_DISC = 2'((DISCARD > 0) ? (DISCARD - 1) : 0);
    localparam logic [2:0]          c_LAST_CH   = 3'(NUM_CH - 1);

    // State encoding
    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_DISCARD = 2'd1;
    localparam logic [1:0] c_S_ACCUM   = 2'd2;

    // State entered whenever a new channel (or a restart) begins: with no
    // settling conversions to drop, go straight to accumulation.
    localparam logic [1:0] c_S_START = (DISCARD == 0) ? c_S_ACCUM : c_S_DISCARD;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          r_disc_cnt;
    logic [c_SCNT_W-1:0] r_samp_cnt;
    logic [c_ACC_W-1:0]  r_acc;
    logic [2:0]          r_chan;
    logic [11:0]         r_avg_data;
    logic [2:0]          r_avg_chan;
    logic                r_avg_valid;
    logic                r_scan_done;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [1:0]          w_state_nxt;
    logic [1:0]          w_disc_cnt_nxt;
    logic [c_SCNT_W-1:0] w_samp_cnt_nxt;
    logic [c_ACC_W-1:0]  w_acc_nxt;
    logic [2:0]          w_chan_nxt;
    logic [11:0]         w_avg_data_nxt;
    logic [2:0]          w_avg_chan_nxt;
    logic                w_avg_valid_nxt;
    logic                w_scan_done_nxt;

    // Running sum including the current result; on the final sample this is
    // the complete total, so the average is taken from it directly.
    logic [c_ACC_W-1:0]  w_sum;
    logic [11:0]         w_avg;
    logic [2:0]          w_chan_inc;

    assign w_sum      = r_acc + c_ACC_W'(result);
    assign w_avg      = w_sum[AVG_LOG2 +: 12];
    assign w_chan_inc = (r_chan == c_LAST_CH) ? 3'd0 : (r_chan + 3'd1);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_disc_cnt_nxt  = r_disc_cnt;
        w_samp_cnt_nxt  = r_samp_cnt;
        w_acc_nxt       = r_acc;
        w_chan_nxt      = r_chan;
        w_avg_data_nxt  = r_avg_data;
        w_avg_chan_nxt  = r_avg_chan;
        w_avg_valid_nxt = 1'b0;
        w_scan_done_nxt = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                w_disc_cnt_nxt = '0;
                w_samp_cnt_nxt = '0;
                w_acc_nxt      = '0;
                if (enable) begin
                    w_state_nxt = c_S_START;
                end
            end

            c_S_DISCARD: begin
                if (!enable) begin
                    w_state_nxt    = c_S_IDLE;
                    w_disc_cnt_nxt = '0;
                    w_samp_cnt_nxt = '0;
                    w_acc_nxt      = '0;
                end else if (conv_done) begin
                    if (r_disc_cnt == c_LAST_DISC) begin
                        w_state_nxt    = c_S_ACCUM;
                        w_disc_cnt_nxt = '0;
                    end else begin
                        w_disc_cnt_nxt = r_disc_cnt + 2'd1;
                    end
                end
            end

            c_S_ACCUM: begin
                if (!enable) begin
                    // Abandon the partial average; nothing is emitted even if
                    // a conversion completes in this same cycle.
                    w_state_nxt    = c_S_IDLE;
                    w_disc_cnt_nxt = '0;
                    w_samp_cnt_nxt = '0;
                    w_acc_nxt      = '0;
                end else if (conv_done) begin
                    if (r_samp_cnt == c_LAST_SAMP) begin
                        // Emit and move to the next channel on the same edge;
                        // the following cycle is already settling time.
                        w_avg_data_nxt  = w_avg;
                        w_avg_chan_nxt  = r_chan;
                        w_avg_valid_nxt = 1'b1;
                        w_scan_done_nxt = (r_chan == c_LAST_CH);
                        w_chan_nxt      = w_chan_inc;
                        w_acc_nxt       = '0;
                        w_samp_cnt_nxt  = '0;
                        w_disc_cnt_nxt  = '0;
                        w_state_nxt     = c_S_START;
                    end else begin
                        w_acc_nxt      = w_sum;
                        w_samp_cnt_nxt = r_samp_cnt + c_SCNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt    = c_S_IDLE;
                w_disc_cnt_nxt = '0;
                w_samp_cnt_nxt = '0;
                w_acc_nxt      = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_disc_cnt  <= '0;
            r_samp_cnt  <= '0;
            r_acc       <= '0;
            r_chan      <= '0;
            r_avg_data  <= '0;
            r_avg_chan  <= '0;
            r_avg_valid <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_disc_cnt  <= w_disc_cnt_nxt;
            r_samp_cnt  <= w_samp_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_chan      <= w_chan_nxt;
            r_avg_data  <= w_avg_data_nxt;
            r_avg_chan  <= w_avg_chan_nxt;
            r_avg_valid <= w_avg_valid_nxt;
            r_scan_done <= w_scan_done_nxt;
        end
    end

    assign chan      = r_chan;
    assign avg_data  = r_avg_data;
    assign avg_chan  = r_avg_chan;
    assign avg_valid = r_avg_valid;
    assign scan_done = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_avg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_avg
//  Description : Self-checking bench for adc_scan_avg (NUM_CH=8, AVG_LOG2=2,
//                DISCARD=2). Channel vectors come from a table; expected
//                averages are queued when the last sample is driven and
//                compared when avg_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_avg;

    localparam int c_GAP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        conv_done;
    logic [11:0] result;
    logic [2:0]  chan;
    logic [11:0] avg_data;
    logic [2:0]  avg_chan;
    logic        avg_valid;
    logic        scan_done;

    always #5 clk = ~clk;

    adc_scan_avg #(
        .NUM_CH   (8),
        .AVG_LOG2 (2),
        .DISCARD  (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .conv_done (conv_done),
        .result    (result),
        .chan      (chan),
        .avg_data  (avg_data),
        .avg_chan  (avg_chan),
        .avg_valid (avg_valid),
        .scan_done (scan_done)
    );

    typedef struct packed {
        logic [11:0] d0;
        logic [11:0] d1;
        logic [11:0] s0;
        logic [11:0] s1;
        logic [11:0] s2;
        logic [11:0] s3;
        logic [11:0] avg;
        logic [2:0]  ch;
        logic        scan;
    } vec_t;

    typedef struct packed {
        logic [11:0] avg;
        logic [2:0]  ch;
        logic        scan;
        logic [2:0]  nxt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[11];

    function automatic vec_t mk(input logic [11:0] d0, input logic [11:0] d1,
                                input logic [11:0] s0, input logic [11:0] s1,
                                input logic [11:0] s2, input logic [11:0] s3,
                                input logic [11:0] avg, input logic [2:0] ch,
                                input logic scan);
        vec_t v;
        v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
        v.avg = avg; v.ch = ch; v.scan = scan;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One conversion frame: result is only meaningful while conv_done is high,
    // so it is scrambled afterwards to catch sampling outside the pulse.
    task automatic pulse(input logic [11:0] v, input int gap);
        result    = v;
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        result    = 12'h5A5;
        tick(gap);
    endtask

    task automatic run_chan(input vec_t v, input bit b2b);
        exp_t e;
        check("chan_at_start", 32'(chan), 32'(v.ch));
        pulse(v.d0, c_GAP);
        pulse(v.d1, c_GAP);
        pulse(v.s0, c_GAP);
        pulse(v.s1, c_GAP);
        pulse(v.s2, c_GAP);
        e.avg  = v.avg;
        e.ch   = v.ch;
        e.scan = v.scan;
        e.nxt  = (v.ch == 3'd7) ? 3'd0 : v.ch + 3'd1;
        sb_q.push_back(e);
        pulse(v.s3, b2b ? 0 : c_GAP);
    endtask

    // Output monitor: every avg_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (avg_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_avg_valid: got avg_chan=%0d avg_data=%0h expected no strobe (t=%0t)",
                             avg_chan, avg_data, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("avg_data",  32'(avg_data),  32'(mon_e.avg));
                    check("avg_chan",  32'(avg_chan),  32'(mon_e.ch));
                    check("scan_done", 32'(scan_done), 32'(mon_e.scan));
                    check("chan_next", 32'(chan),      32'(mon_e.nxt));
                end
            end else if (scan_done) begin
                checks++;
                errors++;
                $display("FAIL scan_without_valid: got scan_done=1 expected 0 (t=%0t)", $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Full scan plus wrap: channels 0..7, then 0, 1, 2 again.
        tbl[0]  = mk(12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 3'd0, 1'b0);
        tbl[1]  = mk(12'hFFF, 12'hFFF, 12'h001, 12'h002, 12'h003, 12'h004, 12'h002, 3'd1, 1'b0);
        tbl[2]  = mk(12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 3'd2, 1'b0);
        tbl[3]  = mk(12'hFFF, 12'hFFF, 12'd10,  12'd20,  12'd30,  12'd41,  12'h019, 3'd3, 1'b0);
        tbl[4]  = mk(12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h003, 12'h000, 3'd4, 1'b0);
        tbl[5]  = mk(12'h123, 12'h456, 12'h007, 12'h007, 12'h007, 12'h007, 12'h007, 3'd5, 1'b0);
        tbl[6]  = mk(12'hFFF, 12'h000, 12'hABC, 12'h123, 12'h456, 12'h789, 12'h5EF, 3'd6, 1'b0);
        tbl[7]  = mk(12'hFFF, 12'hFFF, 12'h001, 12'h001, 12'h001, 12'h000, 12'h000, 3'd7, 1'b1);
        tbl[8]  = mk(12'hFFF, 12'hFFF, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 3'd0, 1'b0);
        tbl[9]  = mk(12'hFFF, 12'hFFF, 12'h002, 12'h003, 12'h002, 12'h003, 12'h002, 3'd1, 1'b0);
        tbl[10] = mk(12'hFFF, 12'hFFF, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0, 3'd2, 1'b0);

        reset     = 1'b1;
        enable    = 1'b0;
        conv_done = 1'b0;
        result    = 12'h000;
        tick(3);
        check("rst_chan",      32'(chan),      32'd0);
        check("rst_avg_data",  32'(avg_data),  32'd0);
        check("rst_avg_chan",  32'(avg_chan),  32'd0);
        check("rst_avg_valid", 32'(avg_valid), 32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        reset = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(2);

        for (int i = 0; i < 11; i++) begin
            run_chan(tbl[i], 1'b0);
        end

        // Drop enable mid-accumulation on channel 3, with a conversion
        // completing in the same cycle; nothing must be emitted.
        check("dis_chan_start", 32'(chan), 32'd3);
        pulse(12'hFFF, c_GAP);
        pulse(12'hFFF, c_GAP);
        pulse(12'h200, c_GAP);
        pulse(12'h200, c_GAP);
        result    = 12'h300;
        conv_done = 1'b1;
        enable    = 1'b0;
        tick(1);
        conv_done = 1'b0;
        tick(2);
        pulse(12'h400, c_GAP);
        check("dis_chan_held",     32'(chan),     32'd3);
        check("dis_avg_data_held", 32'(avg_data), 32'h0F0);
        check("dis_avg_chan_held", 32'(avg_chan), 32'd2);
        enable = 1'b1;
        tick(2);
        run_chan(mk(12'hFFF, 12'hFFF, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 3'd3, 1'b0), 1'b0);

        // Reset in the middle of accumulating channel 5.
        run_chan(mk(12'hFFF, 12'hFFF, 12'h321, 12'h321, 12'h321, 12'h321, 12'h321, 3'd4, 1'b0), 1'b0);
        pulse(12'hFFF, c_GAP);
        pulse(12'hFFF, c_GAP);
        pulse(12'h777, c_GAP);
        pulse(12'h777, c_GAP);
        check("pre_rst_chan", 32'(chan), 32'd5);
        reset = 1'b1;
        tick(1);
        check("mid_rst_chan",      32'(chan),      32'd0);
        check("mid_rst_avg_data",  32'(avg_data),  32'd0);
        check("mid_rst_avg_chan",  32'(avg_chan),  32'd0);
        check("mid_rst_avg_valid", 32'(avg_valid), 32'd0);
        reset = 1'b0;
        tick(2);
        run_chan(mk(12'hFFF, 12'hFFF, 12'h008, 12'h008, 12'h008, 12'h008, 12'h008, 3'd0, 1'b0), 1'b0);

        // conv_done in the avg_valid cycle is the first discard of channel 2.
        run_chan(mk(12'hFFF, 12'hFFF, 12'h010, 12'h020, 12'h030, 12'h040, 12'h028, 3'd1, 1'b0), 1'b1);
        check("b2b_valid_cycle", 32'(avg_valid), 32'd1);
        run_chan(mk(12'hFFF, 12'hFFF, 12'h003, 12'h002, 12'h001, 12'h000, 12'h001, 3'd2, 1'b0), 1'b0);

        tick(10);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_scan_avg.md
Name: adc_scan_avg

Overview:
- Downstream consumer and channel controller for the 12-bit serial ADC interface.
- Drives the interface's 3-bit channel select and scans channels 0..NUM_CH-1 round-robin.
- Captures one result per conversion frame, discards the settling frames after each channel change, and averages 2^AVG_LOG2 samples per channel.
- Presents each per-channel average with a one-cycle valid strobe to the application logic (display / control loop).

Parameters:
NUM_CH, 8, number of channels scanned (1..8); channel wraps NUM_CH-1 -> 0
AVG_LOG2, 2, log2 of samples averaged per channel (0..4)
DISCARD, 2, conv_done pulses ignored after every channel change, before accumulation (0..3)

Ports:
clk  in  1  system clock, same clock as the ADC interface
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; low holds block idle
conv_done  in  1  one-cycle pulse per conversion frame; result is stable and belongs to the frame just ended (top level derives it from the synchronised ADC_CONVST edge)
result  in  12  conversion result from the ADC interface
chan  out  3  channel select driven to the ADC interface
avg_data  out  12  averaged result, held until next update
avg_chan  out  3  channel that avg_data belongs to
avg_valid  out  1  one-cycle strobe: avg_data/avg_chan updated this cycle
scan_done  out  1  one-cycle strobe coincident with avg_valid for channel NUM_CH-1

Behaviour:
- Clock/reset: single clock clk; reset is synchronous and active-high. All state changes on rising edge of clk.
- Reset values: chan=0, avg_data=0, avg_chan=0, avg_valid=0, scan_done=0. Internal state: state=IDLE, discard counter=0, sample counter=0, accumulator=0.
- Reset overrides all other inputs in the same cycle, including mid-scan; partial accumulations are lost.
- Accumulator width is 12+AVG_LOG2 bits and cannot overflow.
- Average = accumulator >> AVG_LOG2, truncating (floor), no rounding.
- IDLE:
  - chan holds its value; accumulator and counters are cleared.
  - enable=1 -> DISCARD, with chan unchanged.
- DISCARD:
  - Each conv_done increments the discard counter.
  - On the DISCARD-th conv_done -> ACCUM.
  - That pulse's result is not accumulated.
  - DISCARD=0 -> the block goes straight to ACCUM (from IDLE or after a channel change).
- ACCUM:
  - Each conv_done adds result to the accumulator and increments the sample counter.
  - On the 2^AVG_LOG2-th conv_done, the same clock edge:
    - loads avg_data with (acc+result)>>AVG_LOG2 and avg_chan with chan;
    - asserts avg_valid for exactly the next cycle;
    - asserts scan_done if chan==NUM_CH-1;
    - advances chan (NUM_CH-1 wraps to 0), clears accumulator and counters;
    - enters DISCARD.
  - Latency from the final conv_done to avg_valid high is 1 cycle.
- No EMIT state: a conv_done in the cycle avg_valid is high counts as the first discard of the new channel.
- enable low in any non-IDLE state -> IDLE next cycle:
  - accumulator and counters are cleared; chan is held;
  - no avg_valid is generated, even if conv_done is high in that same cycle;
  - avg_data and avg_chan keep their last values.
- enable re-asserted -> resume at DISCARD on the held chan.
- conv_done while in IDLE is ignored.
- result is sampled only in a cycle where conv_done=1 and state=ACCUM; result changes at other times have no effect.
- chan changes only on the emitting edge or on reset, never on any other cycle.
- NUM_CH=1: chan stays 0; scan_done pulses with every avg_valid.
- AVG_LOG2=0: average = the single accumulated sample.

Test Plan:
1. Reset, enable=1, result held at 12'h800, conv_done pulse every 16 clk -> after 2 discards + 4 samples, avg_valid for 1 cycle; avg_data=12'h800, avg_chan=0, chan becomes 1 on the same edge.
2. Channel 0 fed 12'hFFF, 12'hFFF (discarded), then 1, 2, 3, 4 -> avg_data=2 (10>>2, floor); 12'hFFF x4 accumulated -> avg_data=12'hFFF, no overflow.
3. Run 8 full channels -> avg_chan sequence 0..7; scan_done high only with avg_chan=7; chan wraps to 0; the next avg_chan is 0.
4. enable dropped after 2 accumulated samples on chan 3 -> no avg_valid, chan stays 3. Re-enable with result=12'h100 -> 2 discards, then avg_data=12'h100, avg_chan=3.
5. reset pulsed mid-ACCUM on chan 5 -> next cycle chan=0, avg_data=0, avg_valid=0. A subsequent scan restarts at channel 0 with the full discard count.
6. conv_done asserted in the cycle avg_valid is high -> counted as first discard of the new channel. With DISCARD=2, the new channel's avg_valid occurs exactly 1+4 further conv_done pulses later.
